// File: rtl/v810_bus_pkg.sv
// Shared types and constants for the V810 bus-cycle sequencer.
package v810_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, TOUT} state_t;

  typedef struct packed {
    logic [3:0] ws;
    logic       w16;
    logic       en;
  } region_cfg_t;

  localparam int unsigned NREGION    = 8;
  localparam int unsigned REGION_MSB = 26;
  localparam int unsigned REGION_LSB = 24;

endpackage

// File: rtl/bus_region_cfg.sv
// Per-region configuration register file: synchronous write, combinational read.
module bus_region_cfg
  import v810_bus_pkg::*;
#(
  parameter logic [3:0] RST_WS  = 4'd1,
  parameter logic       RST_W16 = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  wr_idx,
  input  logic [5:0]  wr_data,
  input  logic [2:0]  rd_idx,
  output region_cfg_t rd_cfg
);

  localparam region_cfg_t RST_CFG = '{ws: RST_WS, w16: RST_W16, en: 1'b1};

  region_cfg_t [NREGION-1:0] cfg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= {NREGION{RST_CFG}};
    end else if (we) begin
      cfg_q[wr_idx] <= '{ws: wr_data[3:0], w16: wr_data[4], en: wr_data[5]};
    end
  end

  assign rd_cfg = cfg_q[rd_idx];

endmodule

// File: rtl/v810_bus_ctrl.sv
// V810 external bus-cycle sequencer: region decode, chip enables, wait states,
// 16-bit size request and timeout termination of disabled regions.
module v810_bus_ctrl
  import v810_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [3:0]  RST_WS  = 4'd1,
  parameter logic        RST_W16 = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic [31:0] CTLR_A,
  input  logic        CTLR_BCYSTn,
  input  logic        CTLR_DAn,
  output logic        CTLR_READYn,
  output logic        CTLR_SZRQn,
  output logic [7:0]  MEM_nCE,
  input  logic        CFG_WE,
  input  logic [2:0]  CFG_IDX,
  input  logic [5:0]  CFG_DATA,
  output logic        BUS_ERR,
  output logic [2:0]  CUR_REGION
);

  localparam logic [7:0] TOUT_LOAD = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        w16_q, w16_d;
  logic [2:0]  region_q, region_d;
  logic        ready_n_q, ready_n_d;
  logic        szrq_n_q, szrq_n_d;
  logic [7:0]  nce_q, nce_d;
  logic        bus_err_q;
  logic        err_set;
  logic        start;
  logic [2:0]  dec_region;
  region_cfg_t dec_cfg;

  logic unused_addr;
  assign unused_addr = ^{CTLR_A[31:REGION_MSB+1], CTLR_A[REGION_LSB-1:0]};

  assign dec_region = CTLR_A[REGION_MSB:REGION_LSB];

  bus_region_cfg #(
    .RST_WS  (RST_WS),
    .RST_W16 (RST_W16)
  ) u_cfg (
    .clk     (CLK),
    .reset   (RESET),
    .we      (CFG_WE),
    .wr_idx  (CFG_IDX),
    .wr_data (CFG_DATA),
    .rd_idx  (dec_region),
    .rd_cfg  (dec_cfg)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w16_d     = w16_q;
    region_d  = region_q;
    ready_n_d = ready_n_q;
    szrq_n_d  = szrq_n_q;
    nce_d     = nce_q;
    err_set   = 1'b0;
    start     = 1'b0;

    unique case (state_q)
      IDLE: start = ~CTLR_BCYSTn;
      WAIT, TOUT: begin
        if (CTLR_DAn) begin
          state_d = IDLE;
          nce_d   = 8'hFF;
        end else if (state_q == WAIT) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d   = DONE;
            ready_n_d = 1'b0;
            szrq_n_d  = ~w16_q;
          end
        end else if (cnt_q == 8'd0) begin
          // Forced completion: never request 16-bit sizing on a timeout.
          state_d   = DONE;
          ready_n_d = 1'b0;
          err_set   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        ready_n_d = 1'b1;
        szrq_n_d  = 1'b1;
        nce_d     = 8'hFF;
        start     = ~CTLR_DAn & ~CTLR_BCYSTn;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      region_d = dec_region;
      w16_d    = dec_cfg.w16;
      nce_d    = ~(8'b1 << dec_region);
      if (!dec_cfg.en) begin
        cnt_d   = TOUT_LOAD;
        state_d = TOUT;
      end else if (dec_cfg.ws == 4'd0) begin
        cnt_d     = 8'd0;
        state_d   = DONE;
        ready_n_d = 1'b0;
        szrq_n_d  = ~dec_cfg.w16;
      end else begin
        cnt_d   = {4'd0, dec_cfg.ws};
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      w16_q     <= 1'b0;
      region_q  <= 3'd0;
      ready_n_q <= 1'b1;
      szrq_n_q  <= 1'b1;
      nce_q     <= 8'hFF;
      bus_err_q <= 1'b0;
    end else begin
      if (CE) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        w16_q     <= w16_d;
        region_q  <= region_d;
        ready_n_q <= ready_n_d;
        szrq_n_q  <= szrq_n_d;
        nce_q     <= nce_d;
      end
      if (CE && err_set) begin
        bus_err_q <= 1'b1;
      end else if (CFG_WE) begin
        bus_err_q <= 1'b0;
      end
    end
  end

  assign CTLR_READYn = ready_n_q;
  assign CTLR_SZRQn  = szrq_n_q;
  assign MEM_nCE     = nce_q;
  assign BUS_ERR     = bus_err_q;
  assign CUR_REGION  = region_q;

endmodule

// File: tb/tb_v810_bus_ctrl.sv
// Self-checking bench for v810_bus_ctrl: edge-count reference model, vector table,
// directed corner sequences and randomized traffic.
module tb_v810_bus_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, ce, bcyst_n, da_n, cfg_we;
  logic [31:0] a;
  logic [2:0]  cfg_idx;
  logic [5:0]  cfg_data;
  logic        ready_n, szrq_n, bus_err;
  logic [7:0]  mem_nce;
  logic [2:0]  cur_region;

  int checks = 0;
  int errors = 0;

  v810_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK         (clk),
    .RESET       (reset),
    .CE          (ce),
    .CTLR_A      (a),
    .CTLR_BCYSTn (bcyst_n),
    .CTLR_DAn    (da_n),
    .CTLR_READYn (ready_n),
    .CTLR_SZRQn  (szrq_n),
    .MEM_nCE     (mem_nce),
    .CFG_WE      (cfg_we),
    .CFG_IDX     (cfg_idx),
    .CFG_DATA    (cfg_data),
    .BUS_ERR     (bus_err),
    .CUR_REGION  (cur_region)
  );

  always #5 clk = ~clk;

  // Reference model: an access started at CE edge k completes (READYn low) right
  // after CE edge k+ws, or k+TIMEOUT for a disabled region, and ends one edge later.
  logic [3:0] m_ws [8];
  logic       m_w16c [8];
  logic       m_en [8];
  int         m_edge = 0;
  int         m_done = 0;
  logic       m_busy = 1'b0;
  logic       m_w16 = 1'b0;
  logic       m_to = 1'b0;
  logic       m_err = 1'b0;
  logic [2:0] m_r = 3'd0;
  logic [2:0] m_cur = 3'd0;

  function automatic void model_edge();
    logic       do_start;
    logic       err_set;
    logic [2:0] r;
    do_start = 1'b0;
    err_set  = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_err  = 1'b0;
      m_cur  = 3'd0;
      for (int i = 0; i < 8; i++) begin
        m_ws[i]   = 4'd1;
        m_w16c[i] = 1'b0;
        m_en[i]   = 1'b1;
      end
      return;
    end
    if (ce) begin
      m_edge++;
      if (m_busy) begin
        if (da_n) m_busy = 1'b0;
        else if (m_edge == m_done + 1) begin
          m_busy   = 1'b0;
          do_start = !bcyst_n;
        end else if (m_edge == m_done && m_to) err_set = 1'b1;
      end else begin
        do_start = !bcyst_n;
      end
      if (do_start) begin
        r      = a[26:24];
        m_busy = 1'b1;
        m_r    = r;
        m_cur  = r;
        m_w16  = m_en[r] & m_w16c[r];
        m_to   = !m_en[r];
        m_done = m_edge + (m_en[r] ? int'(m_ws[r]) : TIMEOUT);
      end
    end
    if (err_set) m_err = 1'b1;
    else if (cfg_we) m_err = 1'b0;
    if (cfg_we) begin
      m_ws[cfg_idx]   = cfg_data[3:0];
      m_w16c[cfg_idx] = cfg_data[4];
      m_en[cfg_idx]   = cfg_data[5];
    end
  endfunction

  function automatic logic [13:0] model_out();
    logic rdy;
    rdy = m_busy && (m_edge == m_done);
    return {~rdy, ~(rdy && m_w16), (m_busy ? ~(8'b1 << m_r) : 8'hFF), m_err, m_cur};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_outputs", {18'd0, ready_n, szrq_n, mem_nce, bus_err, cur_region},
          {18'd0, model_out()});
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [5:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start(input logic [31:0] addr);
    a = addr; bcyst_n = 1'b0;
    step();
    bcyst_n = 1'b1;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (ready_n === 1'b1 && lat < 300) begin
      step();
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [5:0]  data;
    logic [31:0] addr;
    int          lat;
    logic        szrq;
    logic        err;
  } vec_t;

  vec_t vecs[6];
  int   lat, lat2, lows;

  initial begin
    vecs[0] = '{3'd5, 6'h21, 32'h0500_0000, 1,  1'b1, 1'b0};
    vecs[1] = '{3'd7, 6'h30, 32'h0700_0000, 0,  1'b0, 1'b0};
    vecs[2] = '{3'd2, 6'h2F, 32'h0200_0000, 15, 1'b1, 1'b0};
    vecs[3] = '{3'd3, 6'h00, 32'h0300_0000, 16, 1'b1, 1'b1};
    vecs[4] = '{3'd6, 6'h33, 32'hFE00_0000, 3,  1'b0, 1'b0};
    vecs[5] = '{3'd0, 6'h29, 32'h0800_0000, 9,  1'b1, 1'b0};

    reset = 1'b1; ce = 1'b1; bcyst_n = 1'b1; da_n = 1'b0; cfg_we = 1'b0;
    a = 32'd0; cfg_idx = 3'd0; cfg_data = 6'd0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset_outputs", {19'd0, ready_n, szrq_n, mem_nce, bus_err, cur_region},
          {19'd0, 1'b1, 1'b1, 8'hFF, 1'b0, 3'd0});

    // Default ws=1 on region 5.
    start(32'h0500_0000);
    check("r5_nce", {24'd0, mem_nce}, 32'hDF);
    check("r5_ready_early", {31'd0, ready_n}, 32'd1);
    step();
    check("r5_ready", {30'd0, ready_n, szrq_n}, 32'b01);
    step();
    check("r5_end", {23'd0, ready_n, mem_nce}, {23'd0, 1'b1, 8'hFF});

    // Zero-wait 16-bit region followed back-to-back by region 0.
    cfg_write(3'd7, 6'h30);
    a = 32'h0700_0000; bcyst_n = 1'b0;
    step();
    check("r7_zero_ws", {22'd0, ready_n, szrq_n, mem_nce}, {22'd0, 2'b00, 8'h7F});
    a = 32'h0000_0000;
    step();
    bcyst_n = 1'b1;
    check("b2b_nce", {23'd0, ready_n, mem_nce}, {23'd0, 1'b1, 8'hFE});
    step();
    check("b2b_ready", {30'd0, ready_n, szrq_n}, 32'b01);
    step();

    // ws=15 with CE alternating: completion after 15 CE edges, 30 clocks.
    cfg_write(3'd2, 6'h2F);
    start(32'h0200_0000);
    lat = 0; lat2 = 0;
    while (ready_n === 1'b1 && lat < 100) begin
      ce = lat[0];
      step();
      lat++;
      if (ce) lat2++;
    end
    check("ce_toggle_clocks", lat, 30);
    check("ce_toggle_edges", lat2, 15);
    ce = 1'b0;
    step();
    check("ce_freeze_ready", {31'd0, ready_n}, 32'd0);
    ce = 1'b1;
    step();

    // Disabled region: timeout, sticky error, cleared by a config write.
    cfg_write(3'd3, 6'h00);
    start(32'h0300_0000);
    wait_ready(lat);
    check("tout_latency", lat, TIMEOUT);
    check("tout_flags", {30'd0, szrq_n, bus_err}, 32'b11);
    for (int i = 0; i < 4; i++) step();
    check("tout_sticky", {31'd0, bus_err}, 32'd1);
    cfg_write(3'd5, 6'h21);
    check("err_clear", {31'd0, bus_err}, 32'd0);

    // Reset mid-access aborts with no READYn pulse.
    cfg_write(3'd1, 6'h28);
    start(32'h0100_0000);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_abort", {23'd0, ready_n, mem_nce}, {23'd0, 1'b1, 8'hFF});
    lows = 0;
    for (int i = 0; i < 12; i++) begin step(); if (ready_n === 1'b0) lows++; end
    check("rst_no_pulse", lows, 0);

    // DAn deasserted mid-access aborts the same way.
    cfg_write(3'd1, 6'h28);
    start(32'h0100_0000);
    step(); step();
    da_n = 1'b1;
    step();
    da_n = 1'b0;
    check("dan_abort", {23'd0, ready_n, mem_nce}, {23'd0, 1'b1, 8'hFF});
    lows = 0;
    for (int i = 0; i < 12; i++) begin step(); if (ready_n === 1'b0) lows++; end
    check("dan_no_pulse", lows, 0);

    // Reconfiguring a region in flight affects only the next access.
    cfg_write(3'd4, 6'h26);
    start(32'h0400_0000);
    step();
    cfg_write(3'd4, 6'h20);
    wait_ready(lat);
    check("inflight_latency", lat + 2, 6);
    step();
    start(32'h0400_0000);
    check("next_latency0", {31'd0, ready_n}, 32'd0);
    step();

    // Vector table.
    foreach (vecs[i]) begin
      cfg_write(vecs[i].idx, vecs[i].data);
      start(vecs[i].addr);
      wait_ready(lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_flags", i), {29'd0, szrq_n, bus_err, ~mem_nce[vecs[i].idx]},
            {29'd0, vecs[i].szrq, vecs[i].err, 1'b1});
      step();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      ce       = ($urandom_range(0, 3) != 0);
      bcyst_n  = ($urandom_range(0, 2) != 0);
      da_n     = ($urandom_range(0, 29) == 0);
      cfg_we   = ($urandom_range(0, 19) == 0);
      cfg_idx  = 3'($urandom_range(0, 7));
      cfg_data = 6'($urandom_range(0, 63));
      a        = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
